serial_config_lut_bank: RTL and testbench

//  Bank of NUM_LUTS configurable LUT memories for a SLICEL, loaded from a

---
 rtl/serial_config_lut_bank.sv | 102 ++++++++++
 tb/tb_serial_config_lut_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_config_lut_bank.sv
// Purpose: bank of NUM_LUTS LUT memories, loaded from a serial configuration
//          stream through a shadow register and committed one full frame at a time.
// Ports:   cclk/rst clock and async reset; cen/cin/cabort drive the serial
//          stream; cout continues the daisy chain; cdone pulses once per
//          commit; configured is sticky; addr/out are the LUT read ports.
module serial_config_lut_bank #(
  parameter int ADDR_BITS = 4,
  parameter int NUM_LUTS  = 2
) (
  input  logic                          cclk,
  input  logic                          rst,
  input  logic                          cen,
  input  logic                          cin,
  input  logic                          cabort,
  output logic                          cout,
  output logic                          cdone,
  output logic                          configured,
  input  logic [NUM_LUTS*ADDR_BITS-1:0] addr,
  output logic [NUM_LUTS-1:0]           out
);

  localparam int MEM_SIZE   = 2**ADDR_BITS;
  localparam int TOTAL_BITS = NUM_LUTS*MEM_SIZE;
  localparam int CNT_W      = $clog2(TOTAL_BITS+1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state, state_nxt;
  logic [TOTAL_BITS-1:0]   shadow;
  logic [TOTAL_BITS-1:0]   active;
  logic [CNT_W-1:0]        count;
  logic                    last_bit;
  logic                    shift;
  logic                    commit;

  // abort always wins over a shift, even on the final bit of a frame
  assign shift    = cen && !cabort;
  assign last_bit = (count == CNT_W'(TOTAL_BITS-1));
  assign commit   = shift && last_bit;

  // state register
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    if (cabort) begin
      state_nxt = IDLE;
    end else if (cen) begin
      state_nxt = last_bit ? DONE : LOAD;
    end else begin
      // paused: a partial frame stays in LOAD; DONE always falls back to IDLE
      if (state == DONE || count == '0) state_nxt = IDLE;
      else                              state_nxt = LOAD;
    end
  end

  // outputs of the state machine
  always_comb begin
    cdone = (state == DONE);
  end

  // shadow register and bit counter
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      count  <= '0;
    end else if (cabort) begin
      shadow <= '0;
      count  <= '0;
    end else if (cen) begin
      shadow <= {shadow[TOTAL_BITS-2:0], cin};
      count  <= last_bit ? '0 : count + CNT_W'(1);
    end
  end

  // active contents change only on a full-frame commit, so LUT outputs never
  // see a partial configuration
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      active     <= '0;
      configured <= 1'b0;
    end else if (commit) begin
      active     <= {shadow[TOTAL_BITS-2:0], cin};
      configured <= 1'b1;
    end
  end

  assign cout = shadow[TOTAL_BITS-1];

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    logic [MEM_SIZE-1:0]  lut_bits;
    logic [ADDR_BITS-1:0] lut_addr;
    assign lut_bits = active[i*MEM_SIZE +: MEM_SIZE];
    assign lut_addr = addr[i*ADDR_BITS +: ADDR_BITS];
    assign out[i]   = lut_bits[lut_addr];
  end

endmodule

// File: tb/tb_serial_config_lut_bank.sv
module tb_serial_config_lut_bank;

  localparam int AB   = 4;
  localparam int NL   = 2;
  localparam int MEM  = 16;
  localparam int TOT  = 32;

  logic          cclk = 1'b0;
  logic          rst  = 1'b1;
  logic          cen  = 1'b0;
  logic          cin  = 1'b0;
  logic          cabort = 1'b0;
  logic          cout, cdone, configured;
  logic [NL*AB-1:0] addr = '0;
  logic [NL-1:0] out;

  serial_config_lut_bank #(.ADDR_BITS(AB), .NUM_LUTS(NL)) dut (
    .cclk(cclk), .rst(rst), .cen(cen), .cin(cin), .cabort(cabort),
    .cout(cout), .cdone(cdone), .configured(configured),
    .addr(addr), .out(out)
  );

  always #5 cclk = ~cclk;

  int checks = 0;
  int errors = 0;
  int dcnt   = 0;   // cdone pulses seen

  // behavioural model: bits of the frame in progress, recent stream history,
  // and LUT contents as plain arrays
  logic          frame[$];
  logic          hist[$];
  logic [MEM-1:0] mlut [NL];
  logic          mdone = 1'b0;
  logic          mconf = 1'b0;

  initial begin
    for (int i = 0; i < NL; i++) mlut[i] = '0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NL-1:0] model_out();
    logic [NL-1:0] r;
    for (int i = 0; i < NL; i++) r[i] = mlut[i][addr[i*AB +: AB]];
    return r;
  endfunction

  function automatic logic model_cout();
    if (hist.size() >= TOT) return hist[hist.size()-TOT];
    return 1'b0;
  endfunction

  // called at each active edge with the inputs sampled at that edge
  task automatic model_update();
    mdone = 1'b0;
    if (cabort) begin
      frame.delete();
      hist.delete();
    end else if (cen) begin
      frame.push_back(cin);
      hist.push_back(cin);
      if (hist.size() > TOT) void'(hist.pop_front());
      if (frame.size() == TOT) begin
        // first bit of a frame lands in the top bit of the last LUT
        for (int n = 0; n < TOT; n++) begin
          int p;
          p = TOT-1-n;
          mlut[p/MEM][p%MEM] = frame[n];
        end
        frame.delete();
        mdone = 1'b1;
        mconf = 1'b1;
      end
    end
  endtask

  // compare process, away from the active edge
  always @(negedge cclk) begin
    chk("out", 32'(out), 32'(model_out()));
    chk("cdone", 32'(cdone), 32'(mdone));
    chk("configured", 32'(configured), 32'(mconf));
    chk("cout", 32'(cout), 32'(model_cout()));
    if (cdone === 1'b1) dcnt++;
  end

  task automatic step(input logic c, input logic d, input logic a);
    cen = c; cin = d; cabort = a;
    @(posedge cclk);
    model_update();
    #1;
    addr = NL*AB'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cen = 1'b1;
    cin = 1'($urandom);
    frame.delete();
    hist.delete();
    for (int i = 0; i < NL; i++) mlut[i] = '0;
    mdone = 1'b0;
    mconf = 1'b0;
    repeat (2) @(posedge cclk);
    #1;
    rst = 1'b0;
    cen = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] f, input int first, input int n);
    for (int k = first; k < first+n; k++) step(1'b1, f[31-k], 1'b0);
  endtask

  task automatic set_addr_chk(input string nm, input int lut, input int a, input logic exp);
    addr[lut*AB +: AB] = AB'(a);
    #1;
    chk(nm, 32'(out[lut]), 32'(exp));
  endtask

  logic [31:0] f1, f2, f3;
  int d0;

  initial begin
    // 1. reset with cen high
    #1;
    do_reset();
    chk("rst_configured", 32'(configured), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_cdone", 32'(cdone), 32'd0);
    for (int a = 0; a < MEM; a++) begin
      addr = {AB'(a), AB'(MEM-1-a)};
      #1;
      chk("rst_out", 32'(out), 32'd0);
    end

    // 2. full load
    f1 = {16'hA5A5, 16'h3C3C};
    d0 = dcnt;
    send_bits(f1, 0, 32);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("load_cdone_pulses", 32'(dcnt-d0), 32'd1);
    set_addr_chk("lut1_a0", 1, 0, 1'b1);
    set_addr_chk("lut0_a2", 0, 2, 1'b1);
    set_addr_chk("lut0_a0", 0, 0, 1'b0);
    set_addr_chk("lut1_a1", 1, 1, 1'b0);

    // 3. pause mid-frame; the old frame stays visible
    f2 = 32'h1234_F00D;
    d0 = dcnt;
    send_bits(f2, 0, 20);
    repeat (5) step(1'b0, 1'($urandom), 1'b0);
    set_addr_chk("pause_old_lut1", 1, 0, 1'b1);
    send_bits(f2, 20, 11);
    chk("pause_no_early_commit", 32'(dcnt-d0), 32'd0);
    send_bits(f2, 31, 1);
    step(1'b0, 1'b0, 1'b0);
    chk("pause_commit", 32'(dcnt-d0), 32'd1);
    set_addr_chk("f2_lut0_a0", 0, 0, 1'b1);   // 0xF00D bit0
    set_addr_chk("f2_lut1_a1", 1, 1, 1'b0);   // 0x1234 bit1

    // 4. abort on the final bit
    f3 = 32'hFFFF_0000;
    d0 = dcnt;
    send_bits(f3, 0, 31);
    step(1'b1, f3[0], 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("abort_no_cdone", 32'(dcnt-d0), 32'd0);
    set_addr_chk("abort_active_kept", 0, 0, 1'b1);
    send_bits(f3, 0, 32);
    step(1'b0, 1'b0, 1'b0);
    chk("after_abort_commit", 32'(dcnt-d0), 32'd1);
    set_addr_chk("f3_lut0", 0, 5, 1'b0);
    set_addr_chk("f3_lut1", 1, 5, 1'b1);

    // 5. back-to-back frames; cout replays frame 1 during frame 2
    d0 = dcnt;
    send_bits(f1, 0, 32);
    for (int k = 0; k < 32; k++) begin
      chk("chain_cout", 32'(cout), 32'(f1[31-k]));
      step(1'b1, f2[31-k], 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_cdone_pulses", 32'(dcnt-d0), 32'd2);

    // 6. reset mid-frame
    send_bits(f3, 0, 10);
    do_reset();
    chk("midrst_configured", 32'(configured), 32'd0);
    addr = '1;
    #1;
    chk("midrst_out", 32'(out), 32'd0);
    send_bits(f1, 0, 32);
    step(1'b0, 1'b0, 1'b0);
    set_addr_chk("reload_lut1_a0", 1, 0, 1'b1);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 59) == 0);
    end

    @(negedge cclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
